// File: rtl/i2c_slave.sv
// I2C slave with 7-bit address, byte write/read and no clock stretching.
// Optional 3-sample majority glitch filter on SCL/SDA: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1000110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_s, sda_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Majority of the current and two previous samples, registered: single-clk pulses never win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic       drive_q, drive_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      cnt_q      <= 4'd0;
      drive_q    <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      drive_q    <= drive_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:     if (scl_fall && cnt_q == 4'd8)
                    state_d = (shift_q[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall) state_d = shift_q[0] ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_fall && cnt_q == 4'd8) state_d = WR_ACK;
        WR_ACK:   if (scl_fall) state_d = WR_DATA;
        RD_DATA:  if (scl_fall && cnt_q == 4'd8) state_d = RD_ACK;
        RD_ACK:   if (scl_fall) state_d = shift_q[0] ? WAIT_STOP : RD_DATA;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    drive_d    = drive_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    if (stop_det) begin
      drive_d = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 4'd0;
    end else if (start_det) begin
      drive_d = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == WR_DATA) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              drive_d    = 1'b1;
            end else if (shift_q[7:1] == SLAVE_ADDR) begin
              drive_d = 1'b1;
              busy_d  = 1'b1;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          drive_d = 1'b0;
          cnt_d   = 4'd0;
          if (shift_q[0]) begin
            shift_d  = tx_data;
            tx_req_d = 1'b1;
            drive_d  = ~tx_data[7];
          end
        end
        WR_ACK: if (scl_fall) drive_d = 1'b0;
        RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              drive_d = 1'b0;
              cnt_d   = 4'd0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              drive_d = ~shift_q[6];
            end
          end
        end
        // Master's ACK/NACK lands in shift_q[0] and decides at the following fall.
        RD_ACK: begin
          if (scl_rise) begin
            shift_d = {shift_q[7:1], sda_s};
          end else if (scl_fall && !shift_q[0]) begin
            shift_d  = tx_data;
            tx_req_d = 1'b1;
            drive_d  = ~tx_data[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA      = drive_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
endmodule
